// File: rtl/ultra_pkg.sv
// ultra_pkg: shared types and default timing constants for the ultrasonic
// ranging scheduler and its testbench.
package ultra_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_TRIG,
      ST_WAIT_RISE,
      ST_MEASURE,
      ST_HOLD
   } us_state_t;

   localparam int TRIG_CYCLES_DEF = 1200;
   localparam int SLOT_CYCLES_DEF = 6501200;

   localparam int US_ID_MAX_W = 8;
   localparam int US_CW_MAX   = 32;

   // Fields are sized for the largest supported configuration; the top
   // slices them down to its own parameterised widths.
   typedef struct packed {
      logic [US_ID_MAX_W-1:0] id;
      logic [US_CW_MAX-1:0]   cycles;
      logic                   timeout;
   } us_result_t;

endpackage

// File: rtl/echo_sync.sv
// echo_sync: two-flop synchronizer for one asynchronous echo pin, plus
// single-cycle rise/fall pulses derived from the synchronized level.
module echo_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic echo_in,
   output logic level,
   output logic rise,
   output logic fall
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;
   logic prev_q, prev_d;

   always_comb begin
      meta_d = echo_in;
      sync_d = meta_q;
      prev_d = sync_q;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         prev_q <= 1'b0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign level = sync_q;
   assign rise  = sync_q & ~prev_q;
   assign fall  = ~sync_q & prev_q;

endmodule

// File: rtl/ultrasonic_scheduler.sv
// ultrasonic_scheduler: round-robin trigger/echo engine shared across sensors,
// one fixed-length slot and one result per sensor. Define OBSTACLE_CMP_EN to
// build the per-sensor obstacle threshold comparator.
module ultrasonic_scheduler
   import ultra_pkg::*;
#(
   parameter int NUM_SENSORS = 3,
   parameter int TRIG_CYCLES = TRIG_CYCLES_DEF,
   parameter int SLOT_CYCLES = SLOT_CYCLES_DEF,
   parameter int CW          = 23
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           enable,
   input  logic [NUM_SENSORS-1:0]         echo,
   input  logic [CW-1:0]                  thresh_cycles,
   output logic [NUM_SENSORS-1:0]         trig,
   output logic                           dist_valid,
   output logic [$clog2(NUM_SENSORS)-1:0] dist_id,
   output logic [CW-1:0]                  echo_cycles,
   output logic                           timeout,
   output logic [NUM_SENSORS-1:0]         obstacle
);

   localparam int IW = $clog2(NUM_SENSORS);
   localparam logic [CW-1:0] TRIG_LAST = CW'(TRIG_CYCLES - 1);
   localparam logic [CW-1:0] SLOT_LAST = CW'(SLOT_CYCLES - 1);
   localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};
   localparam logic [IW-1:0] SEL_LAST  = IW'(NUM_SENSORS - 1);

   us_state_t               state_q, state_d;
   logic [CW-1:0]           slot_cnt_q, slot_cnt_d;
   logic [CW-1:0]           echo_cnt_q, echo_cnt_d;
   logic [IW-1:0]           sel_q, sel_d;
   logic [NUM_SENSORS-1:0]  trig_q, trig_d;
   logic                    valid_q, valid_d;
   us_result_t              res_q, res_d;

   logic                    report;
   logic [CW-1:0]           rep_cycles;
   logic                    rep_timeout;
   logic                    echo_sel, echo_level, echo_rise, echo_fall;

   assign echo_sel = echo[sel_q];

   echo_sync u_echo_sync (
      .clk     (clk),
      .rst_n   (rst_n),
      .echo_in (echo_sel),
      .level   (echo_level),
      .rise    (echo_rise),
      .fall    (echo_fall)
   );

   always_comb begin
      state_d     = state_q;
      slot_cnt_d  = slot_cnt_q;
      echo_cnt_d  = echo_cnt_q;
      sel_d       = sel_q;
      valid_d     = 1'b0;
      res_d       = res_q;
      report      = 1'b0;
      rep_cycles  = '0;
      rep_timeout = 1'b0;

      if (state_q != ST_IDLE) begin
         slot_cnt_d = slot_cnt_q + 1'b1;
      end

      case (state_q)
         ST_IDLE: begin
            if (enable) begin
               state_d    = ST_TRIG;
               slot_cnt_d = '0;
               echo_cnt_d = '0;
            end
         end
         ST_TRIG: begin
            if (slot_cnt_q == TRIG_LAST) begin
               state_d = ST_WAIT_RISE;
            end
         end
         ST_WAIT_RISE: begin
            if (echo_rise) begin
               state_d    = ST_MEASURE;
               echo_cnt_d = CW'(1);
            end
         end
         ST_MEASURE: begin
            if (echo_fall) begin
               report      = 1'b1;
               rep_cycles  = echo_cnt_q;
               rep_timeout = 1'b0;
               state_d     = ST_HOLD;
            end else if (echo_level && echo_cnt_q != CNT_MAX) begin
               echo_cnt_d = echo_cnt_q + 1'b1;
            end
         end
         ST_HOLD: begin
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // A slot that never reached HOLD reports a timeout, counting this cycle's echo.
      if (state_q != ST_IDLE && slot_cnt_q == SLOT_LAST) begin
         if (!report && state_q != ST_HOLD) begin
            report      = 1'b1;
            rep_timeout = 1'b1;
            rep_cycles  = (state_q == ST_MEASURE) ? echo_cnt_d : '0;
         end
         sel_d      = (sel_q == SEL_LAST) ? '0 : sel_q + 1'b1;
         slot_cnt_d = '0;
         echo_cnt_d = '0;
         state_d    = enable ? ST_TRIG : ST_IDLE;
      end

      if (report) begin
         valid_d       = 1'b1;
         res_d.id      = US_ID_MAX_W'(sel_q);
         res_d.cycles  = US_CW_MAX'(rep_cycles);
         res_d.timeout = rep_timeout;
      end

      trig_d = '0;
      if (state_d == ST_TRIG) begin
         trig_d = NUM_SENSORS'(1) << sel_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         slot_cnt_q <= '0;
         echo_cnt_q <= '0;
         sel_q      <= '0;
         trig_q     <= '0;
         valid_q    <= 1'b0;
         res_q      <= '0;
      end else begin
         state_q    <= state_d;
         slot_cnt_q <= slot_cnt_d;
         echo_cnt_q <= echo_cnt_d;
         sel_q      <= sel_d;
         trig_q     <= trig_d;
         valid_q    <= valid_d;
         res_q      <= res_d;
      end
   end

   assign trig        = trig_q;
   assign dist_valid  = valid_q;
   assign dist_id     = res_q.id[IW-1:0];
   assign echo_cycles = res_q.cycles[CW-1:0];
   assign timeout     = res_q.timeout;

   logic unused_res_bits;
   assign unused_res_bits = ^res_q;

`ifdef OBSTACLE_CMP_EN
   logic [NUM_SENSORS-1:0] obstacle_q, obstacle_d;

   always_comb begin
      obstacle_d = obstacle_q;
      if (report) begin
         obstacle_d[sel_q] = ~rep_timeout && (rep_cycles <= thresh_cycles);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         obstacle_q <= '0;
      end else begin
         obstacle_q <= obstacle_d;
      end
   end

   assign obstacle = obstacle_q;
`else
   logic unused_thresh;
   assign unused_thresh = ^thresh_cycles;
   assign obstacle      = '0;
`endif

endmodule

// File: tb/tb_ultrasonic_scheduler.sv
// tb_ultrasonic_scheduler: random echo pulses and enable patterns checked
// every cycle against a slot-level timing model of the scheduler.
module tb_ultrasonic_scheduler;

   localparam int NS   = 3;
   localparam int TRIG = 10;
   localparam int SLOT = 100;
   localparam int CW   = 8;

   logic          clk;
   logic          rst_n;
   logic          enable;
   logic [NS-1:0] echo;
   logic [CW-1:0] thresh_cycles;
   logic [NS-1:0] trig;
   logic          dist_valid;
   logic [1:0]    dist_id;
   logic [CW-1:0] echo_cycles;
   logic          timeout;
   logic [NS-1:0] obstacle;

   int checks = 0;
   int errors = 0;

   bit        m_active;
   int        m_sensor, m_k, m_next_sel, m_slot_no;
   bit        m_has;
   int        m_p, m_w, m_rep_k, m_rep_cyc;
   bit        m_rep_to;
   bit        m_valid;
   int        m_id, m_cyc;
   bit        m_to;
   logic [2:0] m_obs;
   bit        force_long;

   ultrasonic_scheduler #(
      .NUM_SENSORS (NS),
      .TRIG_CYCLES (TRIG),
      .SLOT_CYCLES (SLOT),
      .CW          (CW)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .enable        (enable),
      .echo          (echo),
      .thresh_cycles (thresh_cycles),
      .trig          (trig),
      .dist_valid    (dist_valid),
      .dist_id       (dist_id),
      .echo_cycles   (echo_cycles),
      .timeout       (timeout),
      .obstacle      (obstacle)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d (slot cycle %0d, t=%0t)", tag, observed, expected, m_k, $time);
      end
   endtask

   // Echo is seen two cycles late through the synchronizer; a rise counts
   // only once trigger time is over, and the pulse width is the count.
   task automatic planSlot(input bit h, input int p, input int w);
      m_has = h; m_p = p; m_w = w;
      m_rep_k = SLOT - 1; m_rep_cyc = 0; m_rep_to = 1'b1;
      if (h && p + 2 >= TRIG && p + 2 <= SLOT - 2) begin
         if (p + w + 2 <= SLOT - 1) begin
            m_rep_k = p + w + 2; m_rep_cyc = w; m_rep_to = 1'b0;
         end else begin
            m_rep_cyc = SLOT - p - 2;
         end
      end
   endtask

   task automatic startSlot();
      int p;
      m_active = 1'b1;
      m_sensor = m_next_sel;
      m_k      = 0;
      case (m_slot_no)
         0: planSlot(1'b1, 19, 25);
         1: planSlot(1'b0, 0, 1);
         2: planSlot(1'b1, 40, 60);
         3: planSlot(1'b1, 30, 40);
         default: begin
            if (force_long) begin
               planSlot(1'b1, 15, 60);
               force_long = 1'b0;
            end else begin
               p = $urandom_range(0, SLOT - 3);
               planSlot($urandom_range(0, 3) != 0, p, $urandom_range(1, SLOT - p));
            end
         end
      endcase
      m_slot_no++;
   endtask

   task automatic compareAll();
      logic [2:0] exp_trig;
      exp_trig = 3'b000;
      if (m_active && m_k < TRIG) exp_trig[m_sensor] = 1'b1;
      checkOutput("trig", 32'(trig), 32'(exp_trig));
      checkOutput("dist_valid", 32'(dist_valid), 32'(m_valid));
      checkOutput("dist_id", 32'(dist_id), 32'(m_id));
      checkOutput("echo_cycles", 32'(echo_cycles), 32'(m_cyc));
      checkOutput("timeout", 32'(timeout), 32'(m_to));
      checkOutput("obstacle", 32'(obstacle), 32'(m_obs));
   endtask

   // Drive this cycle's inputs, then advance the model across the next edge.
   task automatic applyStimulus(input bit en, input bit rin);
      logic [2:0] e;
      e = 3'($urandom);
      if (m_active) e[m_sensor] = m_has && (m_k >= m_p) && (m_k < m_p + m_w);
      echo   = e;
      enable = en;
      rst_n  = rin;
      m_valid = 1'b0;
      if (!rin) begin
         m_active = 1'b0; m_next_sel = 0;
         m_id = 0; m_cyc = 0; m_to = 1'b0; m_obs = 3'b000;
      end else if (!m_active) begin
         if (en) startSlot();
      end else begin
         if (m_k == m_rep_k) begin
            m_valid = 1'b1; m_id = m_sensor; m_cyc = m_rep_cyc; m_to = m_rep_to;
`ifdef OBSTACLE_CMP_EN
            m_obs[m_sensor] = !m_rep_to && (m_rep_cyc <= int'(thresh_cycles));
`endif
         end
         if (m_k == SLOT - 1) begin
            m_next_sel = (m_sensor + 1) % NS;
            m_active   = 1'b0;
            if (en) startSlot();
         end else begin
            m_k++;
         end
      end
   endtask

   task automatic tick(input bit en, input bit rin);
      compareAll();
      applyStimulus(en, rin);
      @(posedge clk);
      #1;
   endtask

   initial begin
      bit en;
      bit hit;
      rst_n = 1'b0; enable = 1'b0; echo = '0; thresh_cycles = 8'd30;
      m_active = 1'b0; m_next_sel = 0; m_slot_no = 0; m_k = 0; m_sensor = 0;
      m_valid = 1'b0; m_id = 0; m_cyc = 0; m_to = 1'b0; m_obs = 3'b000;
      force_long = 1'b0;
      planSlot(1'b0, 0, 1);
      repeat (2) @(posedge clk);
      #1;

      repeat (2) tick(1'b0, 1'b0);
      tick(1'b1, 1'b1);
      repeat (650) tick(1'b1, 1'b1);

      repeat (160) tick(1'b0, 1'b1);
      repeat (250) tick(1'b1, 1'b1);

      thresh_cycles = 8'($urandom_range(0, 100));
      for (int i = 0; i < 1500; i++) begin
         en = ($urandom_range(0, 19) != 0);
         tick(en, 1'b1);
      end

      force_long = 1'b1;
      hit = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         if (m_active && m_has && m_p == 15 && m_w == 60 && m_k == 30) begin
            hit = 1'b1;
            break;
         end
         tick(1'b1, 1'b1);
      end
      checkOutput("reach_measure", 32'(hit), 32'd1);
      tick(1'b1, 1'b0);
      repeat (2) tick(1'b0, 1'b1);
      repeat (320) tick(1'b1, 1'b1);
      compareAll();

      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
